// File: rtl/seg7_to_hex_capture.sv
// seg7_to_hex_capture
//   Watches an active-low 7-segment pattern (bit0=a .. bit6=g), waits for it to
//   hold steady for STABLE_CYCLES qualified samples, then decodes it back to a
//   hex digit and shifts it into a NUM_DIGITS-deep history. Stable patterns
//   that are not in the decode table raise a one-cycle error pulse instead.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous reset, active-low
//   seg_in   in   [6:0] active-low segment pattern
//   seg_vld  in   qualifier for seg_in (0 = ignore)
//   clr      in   synchronous clear of history, count and FSM (hex_out kept)
//   hex_out  out  [3:0] last accepted digit
//   hex_vld  out  one-cycle pulse per accepted legal digit
//   err      out  one-cycle pulse per accepted illegal pattern
//   digits   out  [4*NUM_DIGITS-1:0] history, newest in the low nibble
//   count    out  [CW-1:0] digits captured, saturating at NUM_DIGITS
module seg7_to_hex_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  localparam int CW           = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic                    seg_vld,
  input  logic                    clr,
  output logic [3:0]              hex_out,
  output logic                    hex_vld,
  output logic                    err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [CW-1:0]           count
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STABLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [6:0] BLANK  = 7'b1111111;

  // Returns {legal, digit}; only exact table matches are legal.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1000000: res = {1'b1, 4'h0};
      7'b1111001: res = {1'b1, 4'h1};
      7'b0100100: res = {1'b1, 4'h2};
      7'b0110000: res = {1'b1, 4'h3};
      7'b0011001: res = {1'b1, 4'h4};
      7'b0010010: res = {1'b1, 4'h5};
      7'b0000010: res = {1'b1, 4'h6};
      7'b1111000: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0011000: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b0000011: res = {1'b1, 4'hB};
      7'b1000110: res = {1'b1, 4'hC};
      7'b0100001: res = {1'b1, 4'hD};
      7'b0000110: res = {1'b1, 4'hE};
      7'b0001110: res = {1'b1, 4'hF};
      default:    res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  logic [1:0]              state_r;
  logic [1:0]              state_n;
  logic [6:0]              latch_r;
  logic [6:0]              latch_n;
  logic [SW-1:0]           cnt_r;
  logic [SW-1:0]           cnt_n;
  logic                    accept_s;
  logic                    qual_s;
  logic [4:0]              dec_s;
  logic [4*NUM_DIGITS-1:0] shifted_s;

  assign qual_s = seg_vld && (seg_in != BLANK);
  // At an accept the latched pattern always equals seg_in, so decode the input.
  assign dec_s  = decode(seg_in);

  // Next-state logic: count consecutive identical qualified samples.
  always_comb begin
    state_n  = state_r;
    latch_n  = latch_r;
    cnt_n    = cnt_r;
    accept_s = 1'b0;
    if (!qual_s) begin
      state_n = IDLE;
      cnt_n   = {SW{1'b0}};
    end else begin
      case (state_r)
        STABLE: begin
          if (seg_in == latch_r) begin
            cnt_n = cnt_r + SW'(1);
          end else begin
            latch_n = seg_in;
            cnt_n   = SW'(1);
          end
        end
        HOLD: begin
          // Same pattern already consumed: stay put without recounting.
          if (seg_in != latch_r) begin
            latch_n = seg_in;
            cnt_n   = SW'(1);
          end else begin
            cnt_n   = cnt_r;
          end
        end
        default: begin
          latch_n = seg_in;
          cnt_n   = SW'(1);
        end
      endcase

      if (state_r == HOLD && seg_in == latch_r) begin
        state_n = HOLD;
      end else if (cnt_n == SW'(STABLE_CYCLES)) begin
        accept_s = 1'b1;
        state_n  = HOLD;
      end else begin
        state_n  = STABLE;
      end
    end
  end

  // History shifted one nibble up with the new digit in the low nibble.
  always_comb begin
    shifted_s      = digits << 4;
    shifted_s[3:0] = dec_s[3:0];
  end

  // State, stability counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      latch_r <= 7'd0;
      cnt_r   <= {SW{1'b0}};
      hex_out <= 4'd0;
      hex_vld <= 1'b0;
      err     <= 1'b0;
      digits  <= {(4*NUM_DIGITS){1'b0}};
      count   <= {CW{1'b0}};
    end else begin
      hex_vld <= 1'b0;
      err     <= 1'b0;
      if (clr) begin
        // Clear wins over any accept on the same edge; hex_out is kept.
        state_r <= IDLE;
        latch_r <= 7'd0;
        cnt_r   <= {SW{1'b0}};
        digits  <= {(4*NUM_DIGITS){1'b0}};
        count   <= {CW{1'b0}};
      end else begin
        state_r <= state_n;
        latch_r <= latch_n;
        cnt_r   <= cnt_n;
        if (accept_s) begin
          if (dec_s[4]) begin
            hex_out <= dec_s[3:0];
            hex_vld <= 1'b1;
            digits  <= shifted_s;
            if (count != CW'(NUM_DIGITS)) begin
              count <= count + CW'(1);
            end else begin
              count <= count;
            end
          end else begin
            err <= 1'b1;
          end
        end else begin
          hex_out <= hex_out;
        end
      end
    end
  end

endmodule
